serial_receiver: RTL and testbench
==================================

# serial_receiver

Serial-to-parallel receiver sitting directly downstream of the team's serial transmitter, on the same clock net the transmitter drives out as its serial clock. It watches the serial data line for a high start marker, shifts in the following DATA_W bits LSB first, and assembles them into a parallel word. Completed words go into a small first-word-fall-through FIFO, which the consumer drains with a Valid/Ready handshake. Words that arrive while the FIFO is full are dropped and flagged as overrun.

## Interface
- DATA_W, 8, bits per frame; must match the transmitter's parallel width.
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2.
- Clk  in  1  system clock; the same net as the transmitter's serial clock output. All sampling is on posedge.
- Rst_n  in  1  asynchronous, active-low reset.
- SDin  in  1  serial data from the transmitter. Idle is low, start marker is high, data follows LSB first.
- PDout  out  DATA_W  head-of-FIFO word. Valid only while Valid=1, don't-care otherwise.
- Valid  out  1  FIFO non-empty.
- Ready  in  1  consumer accepts PDout. A pop occurs on an edge where Valid&Ready=1.
- Busy  out  1  frame in progress (state SHIFT).
- Count  out  $clog2(FIFO_DEPTH)+1  number of words held.
- Overrun  out  1  sticky: a completed word was dropped because the FIFO was full.
- Ovr_clr  in  1  synchronous clear of Overrun.

## Operation
- States: IDLE and SHIFT. Bit counter is $clog2(DATA_W) bits wide; shift register is DATA_W bits.
- IDLE:
  - If SDin=1 on an edge: go to SHIFT and set bitcnt=0.
  - If SDin=0: stay in IDLE.
- SHIFT, on each edge:
  - Shift SDin into the MSB of the shift register, moving existing bits right, so the first data bit ends up at bit 0.
  - Increment bitcnt.
  - On the edge where bitcnt==DATA_W-1, the completed word {SDin, shreg[DATA_W-1:1]} is pushed to the FIFO on that same edge, and the state returns to IDLE.
- After returning to IDLE, SDin is examined on the very next edge, so back-to-back frames need no gap.
- A high data bit inside a frame is never treated as a start marker.
- FIFO push when full: the word is dropped and Overrun is set. Overrun holds until Ovr_clr=1 or reset. If Ovr_clr and a new overrun occur on the same edge, the set wins.
- Push and pop on the same edge:
  - Not full: Count is unchanged.
  - Full: the pop frees a slot and the push is accepted. No overrun, Count stays FIFO_DEPTH.
- Pop when empty: ignored. Count stays 0 and the pointers do not move.
- Pointers carry one extra wrap bit. Full when the indices are equal and the wrap bits differ; empty when both are fully equal.
- Reset values: state IDLE, bitcnt 0, shreg 0, FIFO pointers 0, Valid 0, Count 0, Busy 0, Overrun 0. PDout is don't-care.
- Reset during SHIFT discards the partial word. Reset with words queued empties the FIFO.

## Timing
- Start marker sampled at edge t. Data bits are sampled at edges t+1 .. t+DATA_W.
- The word is written at edge t+DATA_W. Valid and PDout reflect it in the cycle that follows, so latency is DATA_W+1 edges from the start marker.
- Busy is 1 in the cycles after edges t .. t+DATA_W-1.
- Throughput: one word per DATA_W+1 cycles maximum.
- PDout, Valid and Count come from registers and memory with no combinational path from SDin. Only the pop path depends on Ready.

## Structure
- Package serial_pkg holds:
  - the state enum (IDLE, SHIFT);
  - the default DATA_W constant, shared with the transmitter.
- Sub-module sync_fifo (params WIDTH, DEPTH):
  - push, pop, full, empty, count, head;
  - first-word-fall-through;
  - owns the pointers and storage.
- The top level holds the state machine, bit counter, shift register and overrun logic.

## Test plan
- Single frame: SDin = 1 then 1,0,1,0,0,1,0,1 with Ready=0. Valid rises one cycle after the 9th edge, PDout=0xA5, Count=1.
- Back-to-back frames: 0x3C immediately followed by 0xC3, with no idle cycle between. Two words queue in order; Busy is low for exactly one cycle between the frames.
- Overrun: 5 frames, Ready=0, FIFO_DEPTH=4. Count saturates at 4 and Overrun=1. Popping returns the first four words; the fifth is lost. Ovr_clr clears the flag.
- Full with simultaneous pop: FIFO full, Ready=1 on the edge that completes a frame. Count stays 4, Overrun stays 0, and the new word appears last.
- Reset mid-frame: Rst_n low after 4 data bits. All outputs return to their reset values immediately. A following 0x81 frame is received correctly.
- Idle noise: SDin=0 for 50 cycles. Busy, Valid and Count stay 0.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: shared receiver/transmitter constants and the receiver state type.
// No ports; it is imported by the receiver top level.
package serial_pkg;
    localparam int DEF_DATA_W = 8;
    typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/serial_receiver_if.sv
// serial_receiver_if: receiver-side serial input and consumer handshake bundle.
// Ports: sd_in (serial data), ready/ovr_clr (consumer controls),
//        pd_out/valid/busy/count/overrun (receiver status and data).
// Modports: master = transmitter/consumer side, slave = receiver side.
interface serial_receiver_if #(
    parameter int DATA_W     = serial_pkg::DEF_DATA_W,
    parameter int FIFO_DEPTH = 4
);
    logic                        sd_in;
    logic                        ready;
    logic                        ovr_clr;
    logic [DATA_W-1:0]           pd_out;
    logic                        valid;
    logic                        busy;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic                        overrun;
    modport master (output sd_in, ready, ovr_clr, input pd_out, valid, busy, count, overrun);
    modport slave  (input sd_in, ready, ovr_clr, output pd_out, valid, busy, count, overrun);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with wrap-bit pointers.
// Ports: clk, rst_n (async, active low), push/din (write), pop (read),
//        full, empty, count (occupancy), head (oldest word, valid when !empty).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;
    always_comb begin
        empty   = wr_q == rd_q;
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop && !empty;
        // A pop on the same edge frees the slot the push needs when full.
        do_push = push && (!full || do_pop);
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
        count   = wr_q - rd_q;
        head    = mem_q[rd_q[AW-1:0]];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/serial_receiver.sv
// serial_receiver: start-marker framed serial-to-parallel receiver feeding a FWFT FIFO.
// Ports: clk, rst_n (async, active low), bus (serial_receiver_if.slave):
//        sd_in in, ready in, ovr_clr in, pd_out/valid/busy/count/overrun out.
module serial_receiver import serial_pkg::*; #(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_receiver_if.slave   bus
);
    localparam int CW = $clog2(DATA_W);
    state_t            state_q, state_d;
    logic [CW-1:0]     bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] word;
    logic              push, pop, full, empty;
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        push     = 1'b0;
        word     = {bus.sd_in, shreg_q[DATA_W-1:1]};
        if (state_q == IDLE) begin
            if (bus.sd_in) begin
                state_d  = SHIFT;
                bitcnt_d = '0;
            end
        end else begin
            shreg_d  = word;
            bitcnt_d = bitcnt_q + 1'b1;
            // The final bit is written straight from sd_in so the word lands this edge.
            if (bitcnt_q == CW'(DATA_W - 1)) begin
                push    = 1'b1;
                state_d = IDLE;
            end
        end
        pop       = !empty && bus.ready;
        // Setting wins over a same-edge clear.
        overrun_d = (push && full && !pop) ? 1'b1 : bus.ovr_clr ? 1'b0 : overrun_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            overrun_q <= overrun_d;
        end
    end
    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (word),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .count (bus.count),
        .head  (bus.pd_out)
    );
    assign bus.valid   = !empty;
    assign bus.busy    = state_q == SHIFT;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver: directed stimulus with a queue scoreboard checking popped words.
module tb_serial_receiver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] exp_q [$];
    serial_receiver_if #(.DATA_W(8), .FIFO_DEPTH(4)) bus ();
    serial_receiver #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask
    // Monitor: a pop happens on the next posedge whenever valid&ready is seen here.
    always @(negedge clk) begin
        if (rst_n && bus.valid && bus.ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected got=0x%0h expected=none", bus.pd_out);
            end else begin
                check("pop_data", int'(bus.pd_out), int'(exp_q.pop_front()));
            end
        end
    end
    task automatic send(input logic [7:0] b, input bit pop_last);
        bus.sd_in = 1'b1;
        @(posedge clk); #1;
        check("busy_start", int'(bus.busy), 1);
        for (int i = 0; i < 8; i++) begin
            bus.sd_in = b[i];
            if (pop_last && i == 7) bus.ready = 1'b1;
            @(posedge clk); #1;
        end
        bus.sd_in = 1'b0;
        if (pop_last) bus.ready = 1'b0;
    endtask
    task automatic drain();
        bus.ready = 1'b1;
        for (int i = 0; i < 20 && bus.valid; i++) begin
            @(posedge clk); #1;
        end
        bus.ready = 1'b0;
        check("drain_valid", int'(bus.valid), 0);
        check("drain_count", int'(bus.count), 0);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.sd_in = 1'b0;
        bus.ready = 1'b0;
        bus.ovr_clr = 1'b0;
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_count", int'(bus.count), 0);
        check("rst_overrun", int'(bus.overrun), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // Idle noise
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            check("idle_busy", int'(bus.busy), 0);
            check("idle_valid", int'(bus.valid), 0);
            check("idle_count", int'(bus.count), 0);
        end
        // Single frame
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b0);
        check("single_valid", int'(bus.valid), 1);
        check("single_pd", int'(bus.pd_out), 'hA5);
        check("single_count", int'(bus.count), 1);
        check("single_busy", int'(bus.busy), 0);
        drain();
        // Back-to-back frames
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send(8'h3C, 1'b0);
        check("b2b_gap_busy", int'(bus.busy), 0);
        send(8'hC3, 1'b0);
        check("b2b_count", int'(bus.count), 2);
        check("b2b_head", int'(bus.pd_out), 'h3C);
        drain();
        // Overrun: fifth word is dropped
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        check("ovr_pre_flag", int'(bus.overrun), 0);
        send(8'h55, 1'b0);
        check("ovr_count", int'(bus.count), 4);
        check("ovr_flag", int'(bus.overrun), 1);
        drain();
        check("ovr_sticky", int'(bus.overrun), 1);
        bus.ovr_clr = 1'b1;
        @(posedge clk); #1;
        bus.ovr_clr = 1'b0;
        check("ovr_cleared", int'(bus.overrun), 0);
        // Full with simultaneous pop on the completing edge
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h05);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        check("full_count", int'(bus.count), 4);
        send(8'h05, 1'b1);
        check("fullpop_count", int'(bus.count), 4);
        check("fullpop_overrun", int'(bus.overrun), 0);
        check("fullpop_head", int'(bus.pd_out), 'h02);
        drain();
        // Reset mid-frame with a word queued
        send(8'h5A, 1'b0);
        check("prerst_count", int'(bus.count), 1);
        check("prerst_pd", int'(bus.pd_out), 'h5A);
        bus.sd_in = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            bus.sd_in = i[0];
            @(posedge clk); #1;
        end
        check("midframe_busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        bus.sd_in = 1'b0;
        #1;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_valid", int'(bus.valid), 0);
        check("midrst_count", int'(bus.count), 0);
        check("midrst_overrun", int'(bus.overrun), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(8'h81);
        send(8'h81, 1'b0);
        check("post_rst_valid", int'(bus.valid), 1);
        check("post_rst_count", int'(bus.count), 1);
        check("post_rst_pd", int'(bus.pd_out), 'h81);
        drain();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
